// File: rtl/stack_fetch_sequencer.sv
// PC / run-control sequencer for the 9-bit stack machine: launches a program ROM,
// steps the PC (fall-through, branch, stall), stops on halt or watchdog, keeps counters.
module stack_fetch_sequencer #(
    parameter logic [8:0]  HALT_CODE  = 9'h1FF,
    parameter logic [15:0] MAX_CYCLES = 16'd20000,
    parameter int          NUM_PROGS  = 3
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  prog_sel,
    input  logic        abort,
    input  logic [8:0]  inst,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    input  logic        stall,
    output logic [7:0]  pc,
    output logic [1:0]  imem_sel,
    output logic        inst_valid,
    output logic        retire,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        bad_prog,
    output logic [15:0] cycle_count,
    output logic [15:0] insn_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [2:0] NPROGS = 3'(NUM_PROGS);

    state_e      state_q, state_d;
    logic        start_q;
    logic [7:0]  pc_q, pc_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] cyc_q, cyc_d, ins_q, ins_d;
    logic        to_q, to_d, bp_q, bp_d;

    logic        launch, wd_hit;
    logic [15:0] cyc_inc, ins_inc;

    assign launch  = start && !start_q;
    assign wd_hit  = (MAX_CYCLES != 16'd0) && (cyc_q == MAX_CYCLES - 16'd1);
    assign cyc_inc = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
    assign ins_inc = (ins_q == 16'hFFFF) ? ins_q : ins_q + 16'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sel_d   = sel_q;
        cyc_d   = cyc_q;
        ins_d   = ins_q;
        to_d    = to_q;
        bp_d    = bp_q;
        retire  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && abort) begin
                    state_d = IDLE;
                end else if (launch) begin
                    if ({1'b0, prog_sel} < NPROGS) begin
                        sel_d   = prog_sel;
                        pc_d    = 8'd0;
                        cyc_d   = 16'd0;
                        ins_d   = 16'd0;
                        to_d    = 1'b0;
                        bp_d    = 1'b0;
                        state_d = RUN;
                    end else begin
                        bp_d    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // Every non-aborted RUN cycle counts, retired or not.
                    cyc_d = cyc_inc;
                    if (wd_hit) begin
                        to_d    = 1'b1;
                        state_d = DONE;
                    end else if (stall) begin
                        state_d = RUN;
                    end else if (inst == HALT_CODE) begin
                        state_d = DONE;
                    end else begin
                        retire = 1'b1;
                        ins_d  = ins_inc;
                        pc_d   = branch_taken ? branch_target : pc_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            start_q <= 1'b1;
            pc_q    <= 8'd0;
            sel_q   <= 2'd0;
            cyc_q   <= 16'd0;
            ins_q   <= 16'd0;
            to_q    <= 1'b0;
            bp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            pc_q    <= pc_d;
            sel_q   <= sel_d;
            cyc_q   <= cyc_d;
            ins_q   <= ins_d;
            to_q    <= to_d;
            bp_q    <= bp_d;
        end
    end

    assign pc          = pc_q;
    assign imem_sel    = sel_q;
    assign inst_valid  = (state_q == RUN);
    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign timeout     = to_q;
    assign bad_prog    = bp_q;
    assign cycle_count = cyc_q;
    assign insn_count  = ins_q;
endmodule

// File: tb/tb_stack_fetch_sequencer.sv
// Two sequencers (default watchdog and an 8-cycle one) on shared stimulus, each
// compared every cycle against a behavioural run-control model, plus literal checks.
module tb_stack_fetch_sequencer;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       rst_n, start, abort, branch_taken, stall;
    logic [1:0] prog_sel;
    logic [8:0] inst;
    logic [7:0] branch_target;

    logic [7:0]  pc_o[2];
    logic [1:0]  sel_o[2];
    logic        iv_o[2], ret_o[2], busy_o[2], done_o[2], to_o[2], bp_o[2];
    logic [15:0] cyc_o[2], ins_o[2];

    stack_fetch_sequencer u_dut (
        .CLK(CLK), .rst_n(rst_n), .start(start), .prog_sel(prog_sel), .abort(abort),
        .inst(inst), .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .pc(pc_o[0]), .imem_sel(sel_o[0]), .inst_valid(iv_o[0]), .retire(ret_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .timeout(to_o[0]), .bad_prog(bp_o[0]),
        .cycle_count(cyc_o[0]), .insn_count(ins_o[0]));

    stack_fetch_sequencer #(.MAX_CYCLES(16'd8)) u_dut8 (
        .CLK(CLK), .rst_n(rst_n), .start(start), .prog_sel(prog_sel), .abort(abort),
        .inst(inst), .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .pc(pc_o[1]), .imem_sel(sel_o[1]), .inst_valid(iv_o[1]), .retire(ret_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .timeout(to_o[1]), .bad_prog(bp_o[1]),
        .cycle_count(cyc_o[1]), .insn_count(ins_o[1]));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: st 0=idle 1=run 2=done; sq is the previous start level.
    typedef struct {int st; int pc; int sel; int cyc; int ins; int to; int bp; int sq;} mdl_t;
    mdl_t m[2];
    int   mc[2] = '{20000, 8};

    function automatic mdl_t mreset();
        mdl_t r;
        r = '{st:0, pc:0, sel:0, cyc:0, ins:0, to:0, bp:0, sq:1};
        return r;
    endfunction

    function automatic int wd(input mdl_t x, input int lim);
        return (lim != 0 && x.cyc == lim - 1) ? 1 : 0;
    endfunction

    function automatic int retires(input mdl_t x, input int lim);
        return (x.st == 1 && !abort && !wd(x, lim) && !stall && inst != 9'h1FF) ? 1 : 0;
    endfunction

    function automatic mdl_t mstep(input mdl_t x, input int lim);
        mdl_t n = x;
        int   launch = (start && x.sq == 0) ? 1 : 0;
        n.sq = start;
        if (x.st == 1) begin
            if (abort) n.st = 0;
            else begin
                n.cyc = (x.cyc < 65535) ? x.cyc + 1 : 65535;
                if (wd(x, lim)) begin n.to = 1; n.st = 2; end
                else if (stall) ;
                else if (inst == 9'h1FF) n.st = 2;
                else begin
                    n.ins = (x.ins < 65535) ? x.ins + 1 : 65535;
                    n.pc  = branch_taken ? int'(branch_target) : (x.pc + 1) % 256;
                end
            end
        end else if (x.st == 2 && abort) n.st = 0;
        else if (launch) begin
            if (prog_sel < 3) begin
                n.st = 1; n.pc = 0; n.sel = prog_sel; n.cyc = 0; n.ins = 0; n.to = 0; n.bp = 0;
            end else begin
                n.bp = 1; n.st = 2;
            end
        end
        return n;
    endfunction

    // Inputs only change just after posedge, so at negedge they are what the next edge sees.
    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) m[k] = mreset();
            chk($sformatf("pc[%0d]", k), int'(pc_o[k]), m[k].pc);
            chk($sformatf("imem_sel[%0d]", k), int'(sel_o[k]), m[k].sel);
            chk($sformatf("busy[%0d]", k), int'(busy_o[k]), int'(m[k].st == 1));
            chk($sformatf("inst_valid[%0d]", k), int'(iv_o[k]), int'(m[k].st == 1));
            chk($sformatf("done[%0d]", k), int'(done_o[k]), int'(m[k].st == 2));
            chk($sformatf("timeout[%0d]", k), int'(to_o[k]), m[k].to);
            chk($sformatf("bad_prog[%0d]", k), int'(bp_o[k]), m[k].bp);
            chk($sformatf("cycle_count[%0d]", k), int'(cyc_o[k]), m[k].cyc);
            chk($sformatf("insn_count[%0d]", k), int'(ins_o[k]), m[k].ins);
            chk($sformatf("retire[%0d]", k), int'(ret_o[k]), retires(m[k], mc[k]));
            if (rst_n) m[k] = mstep(m[k], mc[k]);
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; prog_sel = 2'd0; abort = 1'b0;
        inst = 9'h000; branch_taken = 1'b0; branch_target = 8'd0; stall = 1'b0;
        repeat (2) cyc();
        chk("reset_pc", int'(pc_o[0]), 0);
        chk("reset_busy", int'(busy_o[0]), 0);
        rst_n = 1'b1;
        cyc();

        // Program 2: five plain instructions then halt.
        prog_sel = 2'd2; start = 1'b1;
        cyc();
        repeat (5) cyc();
        chk("halt_pc_before", int'(pc_o[0]), 5);
        inst = 9'h1FF;
        cyc();
        chk("halt_done", int'(done_o[0]), 1);
        chk("halt_pc", int'(pc_o[0]), 5);
        chk("halt_insn", int'(ins_o[0]), 5);
        chk("halt_cycles", int'(cyc_o[0]), 6);
        chk("halt_sel", int'(sel_o[0]), 2);
        cyc();
        chk("halt_pc_hold", int'(pc_o[0]), 5);

        // Branch from 44, then halt beats a branch.
        start = 1'b0; inst = 9'h000; prog_sel = 2'd0;
        cyc();
        start = 1'b1;
        cyc();
        repeat (44) cyc();
        chk("br_pc44", int'(pc_o[0]), 44);
        branch_taken = 1'b1; branch_target = 8'd4;
        cyc();
        chk("br_to4", int'(pc_o[0]), 4);
        branch_target = 8'd44;
        cyc();
        chk("br_to44", int'(pc_o[0]), 44);
        branch_target = 8'd4; inst = 9'h1FF;
        cyc();
        chk("halt_over_br_done", int'(done_o[0]), 1);
        chk("halt_over_br_pc", int'(pc_o[0]), 44);

        // Stall at pc 10; 8-cycle watchdog fires on the second instance meanwhile.
        branch_taken = 1'b0; inst = 9'h000; start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        repeat (8) cyc();
        chk("wd_timeout", int'(to_o[1]), 1);
        chk("wd_done", int'(done_o[1]), 1);
        chk("wd_cycles", int'(cyc_o[1]), 8);
        repeat (2) cyc();
        chk("stall_pc_pre", int'(pc_o[0]), 10);
        stall = 1'b1;
        repeat (3) begin
            cyc();
            chk("stall_retire", int'(ret_o[0]), 0);
            chk("stall_pc", int'(pc_o[0]), 10);
        end
        chk("stall_cycles", int'(cyc_o[0]), 13);
        chk("stall_insn", int'(ins_o[0]), 10);
        stall = 1'b0; branch_taken = 1'b1; branch_target = 8'd20;
        cyc();
        chk("stall_br_pc", int'(pc_o[0]), 20);
        branch_taken = 1'b0; start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        chk("relaunch_clears_to", int'(to_o[1]), 0);
        chk("relaunch_busy", int'(busy_o[1]), 1);
        chk("start_in_run_ignored", int'(pc_o[0]), 22);

        abort = 1'b1;
        cyc();
        chk("abort_busy", int'(busy_o[0]), 0);
        chk("abort_done", int'(done_o[0]), 0);
        chk("abort_pc", int'(pc_o[0]), 22);
        abort = 1'b0; start = 1'b0;
        cyc();

        // Invalid program select.
        prog_sel = 2'd3; start = 1'b1;
        cyc();
        chk("badprog_flag", int'(bp_o[0]), 1);
        chk("badprog_done", int'(done_o[0]), 1);
        repeat (2) begin
            cyc();
            chk("badprog_busy", int'(busy_o[0]), 0);
        end

        // Start held high through reset release does not launch.
        rst_n = 1'b0;
        cyc();
        prog_sel = 2'd0; rst_n = 1'b1;
        repeat (3) cyc();
        chk("held_start_busy", int'(busy_o[0]), 0);
        start = 1'b0;
        cyc();
        start = 1'b1;
        cyc();
        chk("rearm_busy", int'(busy_o[0]), 1);

        // Asynchronous reset mid-run at pc 37.
        repeat (37) cyc();
        chk("pre_rst_pc", int'(pc_o[0]), 37);
        rst_n = 1'b0;
        #2;
        chk("async_rst_pc", int'(pc_o[0]), 0);
        chk("async_rst_busy", int'(busy_o[0]), 0);
        chk("async_rst_done", int'(done_o[0]), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst_n         = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 7) == 0) start = ~start;
            prog_sel      = 2'($urandom_range(0, 3));
            abort         = ($urandom_range(0, 59) == 0);
            inst          = ($urandom_range(0, 24) == 0) ? 9'h1FF : 9'($urandom);
            branch_taken  = ($urandom_range(0, 4) == 0);
            branch_target = 8'($urandom);
            stall         = ($urandom_range(0, 4) == 0);
            cyc();
        end
        rst_n = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
